// File: rtl/conv_frame_loader.sv
// conv_frame_loader: assembles a channel-major pixel stream into the flat
// multi-channel frame bus used by the convolution layer.
module conv_frame_loader #(
  parameter int ELEM_WIDTH      = 8,
  parameter int MAX_IMG_HEIGHT  = 32,
  parameter int MAX_IMG_WIDTH   = 32,
  parameter int MAX_IN_CHANNELS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [7:0]            cfg_img_height,
  input  logic [7:0]            cfg_img_width,
  input  logic [7:0]            cfg_in_channels,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [ELEM_WIDTH-1:0] s_data,
  input  logic                  s_last,
  output logic                  frame_valid,
  output logic [MAX_IN_CHANNELS*MAX_IMG_HEIGHT*MAX_IMG_WIDTH*ELEM_WIDTH-1:0] frame_data,
  output logic                  busy,
  output logic                  err,
  output logic [1:0]            state_dbg
);

  localparam int FRAME_W = MAX_IN_CHANNELS * MAX_IMG_HEIGHT * MAX_IMG_WIDTH * ELEM_WIDTH;
  localparam int OFF_W   = $clog2(FRAME_W);
  localparam logic [7:0] MAX_H = 8'(MAX_IMG_HEIGHT);
  localparam logic [7:0] MAX_W = 8'(MAX_IMG_WIDTH);
  localparam logic [7:0] MAX_C = 8'(MAX_IN_CHANNELS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [7:0] h_q, w_q, c_q;
  logic [7:0] x_cnt, r_cnt, c_cnt;
  logic       cfg_bad, beat, x_end, r_end, c_end, final_beat, last_bad;
  logic [OFF_W-1:0] wr_off;

  // Handshake: an element transfers on a rising edge where s_valid && s_ready.
  // s_ready is high only in LOAD and does not depend on s_valid; the source
  // must hold s_data/s_last stable while s_valid is high and s_ready is low.

  assign cfg_bad = (cfg_img_height  == 8'd0) || (cfg_img_height  > MAX_H) ||
                   (cfg_img_width   == 8'd0) || (cfg_img_width   > MAX_W) ||
                   (cfg_in_channels == 8'd0) || (cfg_in_channels > MAX_C);

  assign beat       = s_valid && s_ready;
  assign x_end      = (x_cnt == w_q - 8'd1);
  assign r_end      = (r_cnt == h_q - 8'd1);
  assign c_end      = (c_cnt == c_q - 8'd1);
  assign final_beat = x_end && r_end && c_end;
  // s_last must coincide exactly with the final beat of the configured frame
  assign last_bad   = (s_last != final_beat);

  // Bit offset of element (c,r,x) inside the max-size frame bus
  assign wr_off = OFF_W'(((32'(c_cnt) * MAX_IMG_HEIGHT + 32'(r_cnt)) * MAX_IMG_WIDTH
                          + 32'(x_cnt)) * ELEM_WIDTH);

  assign state_dbg = state;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and handshake/status outputs
  always_comb begin
    state_nxt   = state;
    s_ready     = 1'b0;
    busy        = 1'b0;
    frame_valid = 1'b0;
    case (state)
      IDLE: begin
        if (start && !cfg_bad) state_nxt = LOAD;
      end
      LOAD: begin
        s_ready = 1'b1;
        busy    = 1'b1;
        if (beat) begin
          if (last_bad)        state_nxt = IDLE;
          else if (final_beat) state_nxt = DONE;
        end
      end
      DONE: begin
        frame_valid = 1'b1;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Config latch, stream counters, frame assembly and error pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q        <= 8'd0;
      w_q        <= 8'd0;
      c_q        <= 8'd0;
      x_cnt      <= 8'd0;
      r_cnt      <= 8'd0;
      c_cnt      <= 8'd0;
      frame_data <= '0;
      err        <= 1'b0;
    end else begin
      err <= 1'b0;
      if (state == IDLE && start) begin
        if (cfg_bad) begin
          err <= 1'b1;
        end else begin
          h_q        <= cfg_img_height;
          w_q        <= cfg_img_width;
          c_q        <= cfg_in_channels;
          x_cnt      <= 8'd0;
          r_cnt      <= 8'd0;
          c_cnt      <= 8'd0;
          frame_data <= '0;
        end
      end else if (state == LOAD && beat) begin
        if (last_bad) begin
          err        <= 1'b1;
          frame_data <= '0;
        end else begin
          frame_data[wr_off +: ELEM_WIDTH] <= s_data;
          if (x_end) begin
            x_cnt <= 8'd0;
            if (r_end) begin
              r_cnt <= 8'd0;
              c_cnt <= c_cnt + 8'd1;
            end else begin
              r_cnt <= r_cnt + 8'd1;
            end
          end else begin
            x_cnt <= x_cnt + 8'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_conv_frame_loader.sv
// Testbench for conv_frame_loader: stream driver, scoreboard monitor and a
// reference model that places each pixel at its (c,r,x) position.
module tb_conv_frame_loader;

  localparam int EW = 8;
  localparam int MH = 32;
  localparam int MW = 32;
  localparam int MC = 3;
  localparam int FW = MC * MH * MW * EW;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          start = 1'b0;
  logic [7:0]    cfg_h = 8'd0, cfg_w = 8'd0, cfg_c = 8'd0;
  logic          s_valid = 1'b0, s_last = 1'b0;
  logic [EW-1:0] s_data = '0;
  logic          s_ready, frame_valid, busy, err;
  logic [FW-1:0] frame_data;
  logic [1:0]    state_dbg;

  conv_frame_loader #(
    .ELEM_WIDTH(EW), .MAX_IMG_HEIGHT(MH), .MAX_IMG_WIDTH(MW), .MAX_IN_CHANNELS(MC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .cfg_img_height(cfg_h), .cfg_img_width(cfg_w), .cfg_in_channels(cfg_c),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .frame_valid(frame_valid), .frame_data(frame_data),
    .busy(busy), .err(err), .state_dbg(state_dbg)
  );

  // ---------------- scoreboard state ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [FW-1:0] exp_q[$];
  int            lat_q[$];
  int            err_exp   = 0;
  int            first_cyc = 0;
  logic [FW-1:0] last_good = '0;
  logic [EW-1:0] pix [MC][MH][MW];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_frame(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    int idx;
    idx = 0;
    n_tests++;
    if (act !== exp) begin
      for (int i = 0; i < FW / EW; i++) begin
        if (act[i*EW +: EW] !== exp[i*EW +: EW]) begin
          idx = i;
          break;
        end
      end
      n_fail++;
      $display("FAIL %s: byte %0d got %0h expected %0h", name, idx,
               act[idx*EW +: EW], exp[idx*EW +: EW]);
    end
  endtask

  // Reference model: each pixel lands at ((c*MH + r)*MW + x), everything else 0
  function automatic logic [FW-1:0] model_frame();
    logic [FW-1:0] v;
    v = '0;
    for (int c = 0; c < MC; c++)
      for (int r = 0; r < MH; r++)
        for (int x = 0; x < MW; x++)
          v[((c * MH + r) * MW + x) * EW +: EW] = pix[c][r][x];
    return v;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin : monitor
    logic [FW-1:0] e;
    int            l;
    if (rst_n) begin
      if (frame_valid) begin
        check("s_ready_in_done", s_ready, 1'b0);
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_frame_valid: got 1 expected 0");
        end else begin
          e = exp_q.pop_front();
          l = lat_q.pop_front();
          check_frame("frame_data", frame_data, e);
          if (l >= 0) check("frame_latency", 64'(cyc - first_cyc + 1), 64'(l));
        end
      end
      if (err) begin
        check("err_expected", 64'(err_exp > 0), 64'd1);
        if (err_exp > 0) err_exp--;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_start(input int h, input int w, input int c);
    cfg_h = h[7:0];
    cfg_w = w[7:0];
    cfg_c = c[7:0];
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    // later cfg changes must not affect the frame in progress
    cfg_h = 8'($urandom);
    cfg_w = 8'($urandom);
    cfg_c = 8'($urandom);
  endtask

  task automatic drive_beat(input logic [EW-1:0] d, input logic lst, input int gap,
                            output int acc_cyc);
    bit done;
    int t;
    done    = 1'b0;
    t       = 0;
    acc_cyc = 0;
    for (int g = 0; g < gap; g++) begin
      s_valid = 1'b0;
      @(posedge clk); #1;
    end
    s_valid = 1'b1;
    s_data  = d;
    s_last  = lst;
    while (!done) begin
      @(negedge clk);
      if (s_ready) begin
        done    = 1'b1;
        acc_cyc = cyc;
        check("busy_in_load", busy, 1'b1);
      end
      @(posedge clk); #1;
      if (!done) begin
        t++;
        if (t > 20) begin
          n_tests++;
          n_fail++;
          $display("FAIL beat_timeout: got s_ready=0 expected 1");
          done = 1'b1;
        end
      end
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // dmode: 0 random, 1 flat index mod 256, 2 base+k
  // gmode: 0 continuous, 1 valid every other cycle, 2 random gaps
  // lmode: 0 correct s_last, 1 early s_last at bad_pos (abort), 2 no s_last on final
  task automatic run_frame(input int h, input int w, input int c, input int dmode,
                           input int base, input int gmode, input int lmode,
                           input int bad_pos, input bit poke);
    logic [EW-1:0] sq[$];
    int n, acc, gap, ci, ri, xi;
    logic [EW-1:0] d;
    logic lst;
    n = h * w * c;
    for (int a = 0; a < MC; a++)
      for (int b = 0; b < MH; b++)
        for (int e = 0; e < MW; e++)
          pix[a][b][e] = '0;
    for (int k = 0; k < n; k++) begin
      ci = k / (h * w);
      ri = (k / w) % h;
      xi = k % w;
      if (dmode == 0)      d = 8'($urandom);
      else if (dmode == 1) d = 8'(((ci * MH + ri) * MW + xi) % 256);
      else                 d = 8'(base + k);
      sq.push_back(d);
      pix[ci][ri][xi] = d;
    end
    if (lmode == 0) begin
      last_good = model_frame();
      exp_q.push_back(last_good);
      lat_q.push_back(gmode == 0 ? n + 1 : -1);
    end else begin
      err_exp++;
    end
    do_start(h, w, c);
    for (int k = 0; k < n; k++) begin
      lst = (lmode == 0) ? (k == n - 1) : (lmode == 1) ? (k == bad_pos) : 1'b0;
      gap = (gmode == 0) ? 0 : (gmode == 1) ? 1 : int'($urandom_range(0, 2));
      if (poke && k == 2) begin
        cfg_h = 8'd1; cfg_w = 8'd1; cfg_c = 8'd1;
        start = 1'b1;
      end
      drive_beat(sq[k], lst, gap, acc);
      start = 1'b0;
      if (k == 0) first_cyc = acc;
      if (lmode == 1 && k == bad_pos) break;
    end
    if (poke) begin
      // start during DONE must be ignored
      cfg_h = 8'd1; cfg_w = 8'd1; cfg_c = 8'd1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    if (lmode != 0) begin
      @(negedge clk);
      check_frame("frame_zero_after_err", frame_data, '0);
      check("idle_after_err_busy", busy, 1'b0);
      check("idle_after_err_ready", s_ready, 1'b0);
      last_good = '0;
      @(posedge clk); #1;
    end
  endtask

  // ---------------- stimulus ----------------
  int bad_cfg [3][3] = '{'{3, 3, 4}, '{0, 2, 1}, '{2, 33, 1}};
  int dummy;

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_s_ready", s_ready, 1'b0);
    check("reset_frame_valid", frame_valid, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_err", err, 1'b0);
    check_frame("reset_frame_data", frame_data, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 2x2x1 frame, data 1..4
    run_frame(2, 2, 1, 2, 1, 0, 0, 0, 1'b0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check_frame("frame_hold", frame_data, last_good);
    @(posedge clk); #1;

    // 1x3x2 frame with valid toggling, data 10..15
    run_frame(1, 3, 2, 2, 10, 1, 0, 0, 1'b0);

    // out-of-range configs: err pulse, stay idle, frame untouched
    for (int i = 0; i < 3; i++) begin
      err_exp++;
      do_start(bad_cfg[i][0], bad_cfg[i][1], bad_cfg[i][2]);
      @(negedge clk);
      check("badcfg_s_ready", s_ready, 1'b0);
      check("badcfg_busy", busy, 1'b0);
      check_frame("badcfg_frame_hold", frame_data, last_good);
      repeat (2) @(posedge clk);
      #1;
    end

    // s_last early, and s_last missing on final beat
    run_frame(2, 2, 1, 0, 0, 0, 1, 1, 1'b0);
    run_frame(2, 2, 1, 0, 0, 0, 2, 0, 1'b0);

    // full-size frame, continuous stream, data = index mod 256
    run_frame(32, 32, 3, 1, 0, 0, 0, 0, 1'b0);

    // reset after 5 beats of a 4x4x1 frame
    do_start(4, 4, 1);
    for (int k = 0; k < 5; k++) drive_beat(8'(k + 100), 1'b0, 0, dummy);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_mid_s_ready", s_ready, 1'b0);
    check("rst_mid_frame_valid", frame_valid, 1'b0);
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_err", err, 1'b0);
    check_frame("rst_mid_frame_data", frame_data, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_frame(4, 4, 1, 0, 0, 0, 0, 0, 1'b0);

    // random frames, one with start pokes during LOAD and DONE
    for (int i = 0; i < 6; i++) begin
      if (i == 2)
        run_frame(2, 2, 2, 0, 0, 0, 0, 0, 1'b1);
      else
        run_frame(int'($urandom_range(1, 6)), int'($urandom_range(1, 6)),
                  int'($urandom_range(1, 3)), 0, 0, int'($urandom_range(0, 2)), 0, 0, 1'b0);
    end

    repeat (4) @(posedge clk);
    #1;
    check("pending_frames", 64'(exp_q.size()), 64'd0);
    check("pending_errs", 64'(err_exp), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "timeout");
  end

endmodule
